mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sits directly downstream of the instruction and data caches. Owns the single RAM port.
- Arbitrates icache word fetches against dcache block fills and write-backs, which are two-word bursts with block offset 0 then 1.
- Presents one RAM request per cycle and returns per-requester wait/load.
- Data side gets priority, with a bounded-starvation guarantee for instruction fetch.

Parameters:
- WORD_W, 32, data and address width.
- STARVE_MAX, 4, maximum consecutive data grants while iREN is pending before the instruction side is forced in.

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- iREN  in  1  icache read request
- iaddr  in  WORD_W  icache word address
- iwait  out  1  low for exactly the cycle iload is valid
- iload  out  WORD_W  fetched instruction word
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  WORD_W  dcache word address; bit 2 is the block offset
- dstore  in  WORD_W  write data
- dwait  out  1  low for exactly the cycle the data access completes
- dload  out  WORD_W  read data
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3 (ramstate_t)

Behaviour:
- Reset: state IDLE, starvation count 0, lock 0.
- Reset output values: ramREN=ramWEN=0, ramaddr=ramstore=0, iwait=dwait=1, iload=dload=0.
- Reset mid-burst abandons the burst; no RAM strobe is asserted in the cycle after nRST rises.
- States: IDLE, D_ACT, I_ACT.
- IDLE arbitration (registered, one cycle of arbitration latency, no RAM strobes in IDLE):
  - Data request (dREN|dWEN) and (iREN==0 or count<STARVE_MAX) -> D_ACT.
  - Else iREN -> I_ACT.
  - Else stay in IDLE.
- D_ACT:
  - Drive ramaddr=daddr and ramstore=dstore.
  - Drive ramWEN=dWEN, and ramREN=dREN&~dWEN; write wins if both are asserted.
  - On ramstate==ACCESS: dwait=0 and dload=ramload for that cycle.
    - If daddr[2]==0, set lock and stay in D_ACT for the second word.
    - Else clear lock, go to IDLE, and count+=1 if iREN (saturating at STARVE_MAX).
  - Request dropped (dREN|dWEN==0) -> IDLE, lock cleared, RAM strobes low that same cycle.
- I_ACT:
  - Drive ramREN=1, ramaddr=iaddr.
  - On ACCESS: iwait=0, iload=ramload, count cleared, go to IDLE.
  - iREN dropped -> IDLE.
- While lock is set, the instruction side is never granted, even if count==STARVE_MAX. Starvation is only checked at burst boundaries.
- ramstate BUSY, FREE or ERROR in an ACT state: hold all strobes, wait outputs stay 1, stay in state.
- The ungranted requester always sees wait=1 and load=0.
- Simultaneous iREN and data request in IDLE with count<STARVE_MAX: data wins.
- Counter is width-sized to hold STARVE_MAX, and never wraps.

Optional Feature:
- Macro: MEMARB_STATS_EN.
- When defined, three 32-bit output ports are added:
  - stat_dacc: completed data words.
  - stat_iacc: completed instruction words.
  - stat_err: cycles with ramstate==ERROR while in an ACT state.
- All three reset to 0 and wrap modulo 2^32.
- When undefined, these ports and their registers do not exist; behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg adds:
  - arb_state_t enum {IDLE, D_ACT, I_ACT}.
  - Constant ARB_STARVE_MAX_DEF=4.
  - ramstate_t is reused as is.
- One natural sub-module: arb_starve_ctr, a saturating counter with inc/clear/limit and output `starved`.

Test Plan:
- Isolated fetch: iREN=1, iaddr=0x40, RAM ACCESS on the 2nd cycle in I_ACT, ramload=0xDEADBEEF -> one-cycle IDLE, then iwait=0 and iload=0xDEADBEEF exactly once, then IDLE.
- Data burst: dREN with daddr=0x100 then 0x104, ACCESS each after 2 BUSY cycles -> two dwait=0 pulses, lock held; iREN asserted mid-burst never granted until after the 0x104 access.
- Contention and starvation: dREN and iREN continuously high, single-word data accesses at blkoff=1 -> after 4 data grants the 5th grant goes to icache, and count returns to 0.
- Write precedence: dREN=dWEN=1, daddr=0x3100, dstore=0x7 -> ramWEN=1, ramREN=0, ramstore=0x7.
- Abort: dREN dropped while ramstate=BUSY in D_ACT -> ramREN=0 the same cycle, IDLE next, dwait stays 1.
- Reset mid-burst: nRST low after the first word of a burst -> all outputs at reset values; after release, a fresh request starts from IDLE, with stat_* equal to 0 when MEMARB_STATS_EN is defined.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU-side types: RAM port handshake states and memory arbiter states.
package cpu_types_pkg;

  // Handshake state reported by the RAM port.
  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  // Memory arbiter ownership of the RAM port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACT = 2'd1,
    I_ACT = 2'd2
  } arb_state_t;

  // Default number of consecutive data grants tolerated while a fetch waits.
  localparam int ARB_STARVE_MAX_DEF = 4;

endpackage : cpu_types_pkg

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while the instruction side waits.
// starved_o is raised once the count reaches LIMIT; clear wins over increment.
module arb_starve_ctr
  import cpu_types_pkg::*;
#(
  parameter int  LIMIT = ARB_STARVE_MAX_DEF,
  localparam int CW    = $clog2(LIMIT + 1)
) (
  input  logic CLK,
  input  logic nRST,
  input  logic inc_i,
  input  logic clr_i,
  output logic starved_o
);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear, or increment without ever passing LIMIT.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q < CW'(LIMIT))) begin
      count_d = count_q + CW'(1);
    end
  end

  // Count register.
  // NOTE: asynchronous active-low reset; every flop here uses <= so all
  // registers sample the same pre-edge values.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) count_q <= '0;
    else       count_q <= count_d;
  end

  assign starved_o = (count_q >= CW'(LIMIT));

endmodule : arb_starve_ctr

// File: rtl/mem_arbiter.sv
// Arbiter for the single RAM port shared by the icache (word fetches) and the
// dcache (two-word block fills/write-backs, offset 0 then 1). The data side has
// priority; after STARVE_MAX consecutive data grants with a fetch pending, the
// next grant taken at a burst boundary goes to the instruction side.
// Optional build macro MEMARB_STATS_EN adds stat_dacc/stat_iacc/stat_err.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W     = 32,
  parameter int STARVE_MAX = ARB_STARVE_MAX_DEF
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [WORD_W-1:0] iaddr,
  output logic              iwait,
  output logic [WORD_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [WORD_W-1:0] daddr,
  input  logic [WORD_W-1:0] dstore,
  output logic              dwait,
  output logic [WORD_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [WORD_W-1:0] ramaddr,
  output logic [WORD_W-1:0] ramstore,
  input  logic [WORD_W-1:0] ramload,
  input  logic [1:0]        ramstate
`ifdef MEMARB_STATS_EN
  ,
  output logic [31:0]       stat_dacc,
  output logic [31:0]       stat_iacc,
  output logic [31:0]       stat_err
`endif
);

  arb_state_t state_q, state_d;
  logic       lock_q, lock_d;
  logic       ctr_inc, ctr_clr, starved;
  logic       data_req;
  ramstate_t  rs;

  assign rs       = ramstate_t'(ramstate);
  assign data_req = dREN | dWEN;

  arb_starve_ctr #(.LIMIT(STARVE_MAX)) u_starve (
    .CLK      (CLK),
    .nRST     (nRST),
    .inc_i    (ctr_inc),
    .clr_i    (ctr_clr),
    .starved_o(starved)
  );

  // Next state, burst lock and all port outputs.
  // NOTE: every output gets a default before the case so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    lock_d   = lock_q;
    ctr_inc  = 1'b0;
    ctr_clr  = 1'b0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = 1'b1;
    iload    = '0;
    dwait    = 1'b1;
    dload    = '0;

    case (state_q)
      IDLE: begin
        // Starvation only matters between bursts; the lock keeps the
        // instruction side out regardless of the count.
        if (data_req && (!iREN || !starved || lock_q)) begin
          state_d = D_ACT;
        end else if (iREN && !lock_q) begin
          state_d = I_ACT;
        end
      end

      D_ACT: begin
        if (!data_req) begin
          state_d = IDLE;
          lock_d  = 1'b0;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          if (rs == ACCESS) begin
            dwait = 1'b0;
            dload = ramload;
            if (!daddr[2]) begin
              lock_d = 1'b1;
            end else begin
              lock_d  = 1'b0;
              state_d = IDLE;
              ctr_inc = iREN;
            end
          end
        end
      end

      I_ACT: begin
        if (!iREN) begin
          state_d = IDLE;
        end else begin
          ramREN  = 1'b1;
          ramaddr = iaddr;
          if (rs == ACCESS) begin
            iwait   = 1'b0;
            iload   = ramload;
            ctr_clr = 1'b1;
            state_d = IDLE;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and burst lock registers.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lock_q  <= lock_d;
    end
  end

`ifdef MEMARB_STATS_EN
  logic [31:0] stat_dacc_q, stat_iacc_q, stat_err_q;
  logic        d_done, i_done, err_cyc;

  assign d_done  = (state_q == D_ACT) && data_req && (rs == ACCESS);
  assign i_done  = (state_q == I_ACT) && iREN && (rs == ACCESS);
  assign err_cyc = (state_q != IDLE) && (rs == ERROR);

  // Wrapping event counters for completed words and error cycles.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stat_dacc_q <= '0;
      stat_iacc_q <= '0;
      stat_err_q  <= '0;
    end else begin
      if (d_done)  stat_dacc_q <= stat_dacc_q + 32'd1;
      if (i_done)  stat_iacc_q <= stat_iacc_q + 32'd1;
      if (err_cyc) stat_err_q  <= stat_err_q + 32'd1;
    end
  end

  assign stat_dacc = stat_dacc_q;
  assign stat_iacc = stat_iacc_q;
  assign stat_err  = stat_err_q;
`endif

endmodule : mem_arbiter
